shmcp_4_prog_loader: RTL and testbench

Upstream program-load stage for the SHMCP_4 4-bit microcoded processor. Accepts a length-prefixed byte stream from a host over a valid/ready handshake and buffers it in a small FIFO. Replays the payload to the processor as consecutive `load`/`instr` write cycles, then holds the processor in run mode (`state`=1) until reset. Replaces hand-sequenced `load`/`instr`/`state` driving at system level.

---
 rtl/shmcp_4_prog_loader.sv | 132 +++++++++++++
 tb/tb_shmcp_4_prog_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shmcp_4_prog_loader.sv
// Program loader: takes a length-prefixed byte stream and replays it as load/instr writes, then holds run mode.
// Latency: a payload byte into an empty FIFO appears on o_load/o_instr two edges after acceptance; outputs are registered.
// Backpressure: o_in_ready drops when the FIFO is full or all N payload bytes are in; i_pause freezes issue only.
module shmcp_4_prog_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_DEPTH  = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    input  logic       i_pause,
    output logic       o_load,
    output logic [7:0] o_instr,
    output logic       o_state,
    output logic       o_busy,
    output logic       o_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MEM_DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [8:0]    MEM_MAX = 9'(MEM_DEPTH);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_RUN
    } state_t;

    state_t        r_fsm;
    state_t        w_fsm_nxt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_acc;
    logic [CW-1:0] r_iss;
    logic [GW-1:0] r_gap;

    logic w_full;
    logic w_empty;
    logic w_xfer;
    logic w_push;
    logic w_pop;
    logic w_hdr_ok;
    logic w_hdr_acc;
    logic w_hdr_bad;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_xfer    = i_in_valid && o_in_ready;
    assign w_hdr_ok  = (i_in_data != 8'h00) && ({1'b0, i_in_data} <= MEM_MAX);
    assign w_hdr_acc = w_xfer && (r_fsm == S_IDLE) && w_hdr_ok;
    assign w_hdr_bad = w_xfer && (r_fsm == S_IDLE) && !w_hdr_ok;
    assign w_push    = w_xfer && (r_fsm == S_LOAD);
    assign w_pop     = (r_fsm == S_LOAD) && !w_empty && !i_pause;

    // Host ready: only from FSM/FIFO state, never from i_in_valid.
    always_comb begin
        o_in_ready = 1'b0;
        case (r_fsm)
            S_IDLE:  o_in_ready = 1'b1;
            S_LOAD:  o_in_ready = !w_full && (r_acc < r_len);
            default: o_in_ready = 1'b0;
        endcase
    end

    // Next-state: header opens LOAD, last issue enters GAP, GAP counter releases RUN.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_hdr_acc) w_fsm_nxt = S_LOAD;
            S_LOAD:  if (w_pop && ((r_iss + CW'(1)) == r_len)) w_fsm_nxt = S_GAP;
            S_GAP:   if (r_gap == GAP_END) w_fsm_nxt = S_RUN;
            default: w_fsm_nxt = S_RUN;
        endcase
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_in_data;
    end

    // State, pointers, counters and registered processor-facing outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm   <= S_IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_len   <= '0;
            r_acc   <= '0;
            r_iss   <= '0;
            r_gap   <= '0;
            o_load  <= 1'b0;
            o_instr <= 8'h00;
            o_state <= 1'b0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_hdr_acc) begin
                r_len <= i_in_data[CW-1:0];
                r_acc <= '0;
                r_iss <= '0;
            end
            if (w_push) begin
                r_wp  <= r_wp + 1'b1;
                r_acc <= r_acc + 1'b1;
            end
            if (w_pop) begin
                r_rp    <= r_rp + 1'b1;
                r_iss   <= r_iss + 1'b1;
                o_instr <= r_mem[r_rp[AW-1:0]];
            end
            if (r_fsm != S_GAP)
                r_gap <= '0;
            else if (r_gap != GAP_END)
                r_gap <= r_gap + 1'b1;
            o_load  <= w_pop;
            o_state <= (w_fsm_nxt == S_RUN);
            o_busy  <= (w_fsm_nxt == S_LOAD) || (w_fsm_nxt == S_GAP);
            o_err   <= w_hdr_bad;
        end
    end

endmodule

// File: tb/tb_shmcp_4_prog_loader.sv
// Bench for the program loader: directed scenarios plus randomized programs.
// Expected writes are queued when the host transfer happens; a monitor pops them on every o_load.
// Host stalls on o_in_ready; every wait is bounded.
module tb_shmcp_4_prog_loader;
    localparam int FD  = 4;
    localparam int MD  = 16;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       pause = 1'b0;
    logic       in_ready, load, state, busy, err;
    logic [7:0] instr;

    shmcp_4_prog_loader #(.FIFO_DEPTH(FD), .MEM_DEPTH(MD), .GAP_CYCLES(GAP)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(in_ready), .i_pause(pause), .o_load(load), .o_instr(instr),
        .o_state(state), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Scoreboard: driver appends, monitor consumes.
    logic [7:0] exp_arr [0:4095];
    int wr_idx = 0, rd_idx = 0;
    int len_arr [0:255];
    int len_wr = 0, len_rd = 0;
    int err_issued = 0, err_seen = 0;
    int writes_seen = 0;
    bit in_run = 1'b0;

    function automatic void chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: reset values, error pulses, write order, gap length, run hold.
    initial begin
        bit r;
        bit exp_e;
        int writes_left = 0;
        int after_cnt = 0;
        bit tracking = 1'b0;
        logic [7:0] last_instr = 8'h00;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            r = rst;
            @(negedge clk);
            if (r) begin
                chk(load == 1'b0, "rst_load", load, 0);
                chk(instr == 8'h00, "rst_instr", instr, 0);
                chk(state == 1'b0, "rst_state", state, 0);
                chk(busy == 1'b0, "rst_busy", busy, 0);
                chk(err == 1'b0, "rst_err", err, 0);
                chk(in_ready == 1'b1, "rst_ready", in_ready, 1);
                rd_idx = wr_idx; len_rd = len_wr; err_seen = err_issued;
                writes_left = 0; tracking = 1'b0; in_run = 1'b0; last_instr = 8'h00;
            end else begin
                exp_e = (err_issued > err_seen);
                if (exp_e) err_seen++;
                chk(err == exp_e, "err", err, exp_e);
                if (load) begin
                    chk(!in_run && (rd_idx != wr_idx), "load_expected", 1, 0);
                    if (rd_idx != wr_idx) begin
                        e = exp_arr[rd_idx % 4096];
                        chk(instr == e, "instr", instr, e);
                        rd_idx++;
                    end
                    last_instr = instr;
                    chk(state == 1'b0 && busy == 1'b1, "load_flags", {state, busy}, 1);
                    if (writes_left == 0 && len_rd < len_wr) begin
                        writes_left = len_arr[len_rd % 256];
                        len_rd++;
                    end
                    if (writes_left > 0) begin
                        writes_left--;
                        if (writes_left == 0) begin
                            tracking = 1'b1;
                            after_cnt = 0;
                        end
                    end
                    writes_seen++;
                end else begin
                    chk(instr == last_instr, "instr_hold", instr, last_instr);
                    if (tracking) begin
                        after_cnt++;
                        if (after_cnt <= GAP) begin
                            chk(state == 1'b0 && busy == 1'b1, "gap", {state, busy}, 1);
                        end else begin
                            chk(state == 1'b1 && busy == 1'b0, "run_start", {state, busy}, 2);
                            tracking = 1'b0;
                            in_run = 1'b1;
                        end
                    end else if (in_run) begin
                        chk(state == 1'b1 && busy == 1'b0, "run_hold", {state, busy}, 2);
                    end else begin
                        chk(state == 1'b0, "pre_run_state", state, 0);
                    end
                end
            end
        end
    end

    // Offer one byte until accepted; record what the loader must do with it.
    task automatic send(input logic [7:0] b, input bit is_hdr, input bit rand_pause);
        int w = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        while (!acc && w <= 200) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                if (is_hdr) begin
                    if (b == 8'h00 || b > MD) err_issued++;
                    else begin
                        len_arr[len_wr % 256] = b;
                        len_wr++;
                    end
                end else begin
                    exp_arr[wr_idx % 4096] = b;
                    wr_idx++;
                end
            end else begin
                w++;
                if (w > 3 && rand_pause) pause = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk(acc, "send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_run();
        int c = 0;
        while (!in_run && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(in_run, "run_reached", in_run, 1);
    endtask

    // Host must be refused while running.
    task automatic probe_closed();
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            chk(in_ready == 1'b0, "run_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] nominal [7];
        int n;
        int base;
        int c;
        nominal = '{8'h06, 8'h2A, 8'h41, 8'h0D, 8'h07, 8'h34, 8'h06};

        // Reset with a byte offered: nothing may be taken.
        in_valid = 1'b1;
        in_data = 8'h05;
        idle(2);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b1, "post_rst_ready", in_ready, 1);
        idle(2);

        // Rejected headers stay in IDLE.
        send(8'h00, 1'b1, 1'b0);
        send(8'h11, 1'b1, 1'b0);
        @(negedge clk);
        chk(in_ready == 1'b1, "idle_after_err", in_ready, 1);
        idle(2);

        // Nominal back-to-back program.
        for (int i = 0; i < 7; i++) send(nominal[i], i == 0, 1'b0);
        @(negedge clk);
        chk(in_ready == 1'b0, "ready_after_last", in_ready, 0);
        wait_run();
        idle(40);
        probe_closed();

        // Largest legal program.
        do_reset(1);
        send(8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1'b0);
        wait_run();
        idle(3);

        // Paused issue: FIFO fills to depth, then host stalls.
        do_reset(1);
        pause = 1'b1;
        send(8'h08, 1'b1, 1'b0);
        for (int i = 0; i < FD; i++) send(8'($urandom), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data = 8'hE1;
        repeat (4) begin
            @(negedge clk);
            chk(in_ready == 1'b0, "bp_ready", in_ready, 0);
            chk(load == 1'b0, "bp_no_load", load, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pause = 1'b0;
        for (int i = FD; i < 8; i++) send(8'($urandom), 1'b0, 1'b0);
        wait_run();
        idle(3);

        // Bursty host: one byte then two idle cycles.
        do_reset(1);
        send(8'h05, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(8'($urandom), 1'b0, 1'b0);
            idle(2);
        end
        wait_run();
        idle(3);

        // Reset after the third write of a six-byte program, then a fresh program.
        do_reset(1);
        base = writes_seen;
        send(8'h06, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b0);
        c = 0;
        while (writes_seen - base < 3 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(writes_seen - base == 3, "midload_writes", writes_seen - base, 3);
        do_reset(1);
        send(8'h03, 1'b1, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b0);
        wait_run();
        idle(5);

        // Randomized programs with random gaps, pause and occasional bad headers.
        for (int t = 0; t < 12; t++) begin
            do_reset(1);
            if ($urandom_range(0, 2) == 0)
                send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)), 1'b1, 1'b0);
            n = $urandom_range(1, MD);
            send(8'(n), 1'b1, 1'b0);
            for (int i = 0; i < n; i++) begin
                pause = 1'($urandom_range(0, 1));
                idle($urandom_range(0, 2));
                send(8'($urandom), 1'b0, 1'b1);
            end
            pause = 1'b0;
            wait_run();
            pause = 1'($urandom_range(0, 1));
            idle($urandom_range(2, 6));
            probe_closed();
            pause = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
